// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared arithmetic sequencer types for the serial multiply/divide datapath
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SUB   = 2'd2,
    DONE  = 2'd3
  } arith_state_t;

  // Width of a down-counter that must hold the value n itself.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/div_serial_if.sv
// rtl/div_serial_if.sv - start/end-pulse divider bus; optional div_by_zero under DIV_ZERO_DETECT_EN
interface div_serial_if #(
  parameter int ND = 32,
  parameter int NV = 32
);

  logic          start;
  logic [ND-1:0] dividend;
  logic [NV-1:0] divisor;
  logic          end_div;
  logic [ND-1:0] quotient;
  logic [NV-1:0] remainder;
`ifdef DIV_ZERO_DETECT_EN
  logic          div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  end_div, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output end_div, quotient, remainder, div_by_zero
  );
`else
  modport master (
    output start, dividend, divisor,
    input  end_div, quotient, remainder
  );

  modport slave (
    input  start, dividend, divisor,
    output end_div, quotient, remainder
  );
`endif

endinterface

// File: rtl/div_trial_sub.sv
// rtl/div_trial_sub.sv - combinational NV+1-bit trial subtract of the divisor from the partial remainder
module div_trial_sub #(
  parameter int NV = 32
) (
  input  logic [NV:0]   r,
  input  logic [NV-1:0] d,
  output logic [NV:0]   diff,
  output logic          ge
);

  logic [NV:0] d_ext;

  assign d_ext = {1'b0, d};
  assign ge    = (r >= d_ext);
  assign diff  = r - d_ext;

endmodule

// File: rtl/div_serial.sv
// rtl/div_serial.sv - restoring shift-subtract unsigned divider; DIV_ZERO_DETECT_EN adds early divide-by-zero exit
module div_serial
  import arith_pkg::*;
#(
  parameter int ND = 32,
  parameter int NV = 32
) (
  input  logic       clock,
  input  logic       reset,
  div_serial_if.slave bus
);

  localparam int CW = cnt_width(ND);

  arith_state_t  state;
  logic [NV:0]   r_q;
  logic [ND-1:0] q_q;
  logic [NV-1:0] d_q;
  logic [CW-1:0] cnt_q;

  logic [NV:0]   trial_diff;
  logic          trial_ge;

  div_trial_sub #(.NV(NV)) u_trial (
    .r    (r_q),
    .d    (d_q),
    .diff (trial_diff),
    .ge   (trial_ge)
  );

`ifdef DIV_ZERO_DETECT_EN
  logic        dz_q;
  logic [NV:0] dz_rem;

  // A zero divisor finishes immediately with the same result the full loop would give.
  assign dz_rem = {1'b0, NV'(bus.dividend)};
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      r_q           <= '0;
      q_q           <= '0;
      d_q           <= '0;
      cnt_q         <= '0;
      bus.end_div   <= 1'b0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
`ifdef DIV_ZERO_DETECT_EN
      dz_q            <= 1'b0;
      bus.div_by_zero <= 1'b0;
`endif
    end else begin
      bus.end_div <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            r_q   <= '0;
            q_q   <= bus.dividend;
            d_q   <= bus.divisor;
            cnt_q <= CW'(ND);
            state <= SHIFT;
`ifdef DIV_ZERO_DETECT_EN
            dz_q            <= 1'b0;
            bus.div_by_zero <= 1'b0;
            if (bus.divisor == '0) begin
              r_q   <= dz_rem;
              q_q   <= '1;
              dz_q  <= 1'b1;
              state <= DONE;
            end
`endif
          end
        end
        SHIFT: begin
          {r_q, q_q} <= {r_q, q_q} << 1;
          cnt_q      <= cnt_q - 1'b1;
          state      <= SUB;
        end
        SUB: begin
          if (trial_ge) begin
            r_q    <= trial_diff;
            q_q[0] <= 1'b1;
          end
          state <= (cnt_q != '0) ? SHIFT : DONE;
        end
        DONE: begin
          bus.quotient  <= q_q;
          bus.remainder <= r_q[NV-1:0];
          bus.end_div   <= 1'b1;
`ifdef DIV_ZERO_DETECT_EN
          bus.div_by_zero <= dz_q;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_serial.sv
// tb/tb_div_serial.sv - directed vector bench for div_serial at ND=NV=32
module tb_div_serial;
  import arith_pkg::*;

  localparam int ND = 32;
  localparam int NV = 32;
`ifdef DIV_ZERO_DETECT_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 65;
`endif

  typedef struct {
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] exp_q;
    logic [31:0] exp_r;
    int          exp_lat;
    bit          b2b;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  div_serial_if #(.ND(ND), .NV(NV)) bus ();

  div_serial #(.ND(ND), .NV(NV)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Presents operands with start for one edge, then returns the edge count to end_div (-1 on timeout).
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, output int lat);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clock); #1;
    bus.start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clock); #1;
      if (bus.end_div === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  vec_t vec [9];
  int   lat;
  int   pulses;

  initial begin
    vec[0] = '{32'd1000000,   32'd7,          32'd142857,     32'd1,      65,   1'b0};
    vec[1] = '{32'd5,         32'd9,          32'd0,          32'd5,      65,   1'b0};
    vec[2] = '{32'hFFFFFFFF,  32'd1,          32'hFFFFFFFF,   32'd0,      65,   1'b0};
    vec[3] = '{32'hFFFFFFFF,  32'hFFFFFFFF,   32'd1,          32'd0,      65,   1'b1};
    vec[4] = '{32'h1234,      32'd0,          32'hFFFFFFFF,   32'h1234,   ZLAT, 1'b0};
    vec[5] = '{32'd12345678,  32'd1000,       32'd12345,      32'd678,    65,   1'b0};
    vec[6] = '{32'h80000000,  32'd3,          32'd715827882,  32'd2,      65,   1'b0};
    vec[7] = '{32'd0,         32'd5,          32'd0,          32'd0,      65,   1'b0};
    vec[8] = '{32'd7,         32'd7,          32'd1,          32'd0,      65,   1'b0};

    // Reset held with start asserted: reset must win.
    reset        = 1'b1;
    bus.start    = 1'b1;
    bus.dividend = 32'd77;
    bus.divisor  = 32'd3;
    repeat (3) @(posedge clock);
    #1;
    check("reset_state", dut.state, IDLE);
    check("reset_quotient", bus.quotient, 0);
    check("reset_remainder", bus.remainder, 0);
    check("reset_end_div", bus.end_div, 0);
`ifdef DIV_ZERO_DETECT_EN
    check("reset_div_by_zero", bus.div_by_zero, 0);
`endif
    bus.start = 1'b0;
    reset     = 1'b0;

    for (int i = 0; i < 9; i++) begin
      if (!vec[i].b2b) @(negedge clock);
      run_div(vec[i].dividend, vec[i].divisor, lat);
      check($sformatf("vec%0d_latency", i), lat, vec[i].exp_lat);
      check($sformatf("vec%0d_quotient", i), bus.quotient, vec[i].exp_q);
      check($sformatf("vec%0d_remainder", i), bus.remainder, vec[i].exp_r);
`ifdef DIV_ZERO_DETECT_EN
      check($sformatf("vec%0d_div_by_zero", i), bus.div_by_zero, (vec[i].divisor == 0));
`endif
    end

    // end_div lasts one cycle and results hold afterwards.
    @(posedge clock); #1;
    check("pulse_width", bus.end_div, 0);
    check("hold_quotient", bus.quotient, 1);

    // Start while busy is ignored and operand changes after capture have no effect.
    @(negedge clock);
    bus.start    = 1'b1;
    bus.dividend = 32'd100;
    bus.divisor  = 32'd7;
    @(posedge clock); #1;
    bus.start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clock); #1;
      if (n == 9) begin
        bus.start    = 1'b1;
        bus.dividend = 32'd50;
        bus.divisor  = 32'd5;
      end else if (n == 10) begin
        bus.start    = 1'b0;
        bus.dividend = 32'd3;
        bus.divisor  = 32'd1;
      end
      if (bus.end_div === 1'b1) begin
        lat = n;
        break;
      end
    end
    check("busy_latency", lat, 65);
    check("busy_quotient", bus.quotient, 14);
    check("busy_remainder", bus.remainder, 2);
    pulses = 0;
    repeat (80) begin
      @(posedge clock); #1;
      if (bus.end_div === 1'b1) pulses++;
    end
    check("busy_no_second_result", pulses, 0);

    // Reset mid-operation aborts with no pulse and clears the outputs.
    @(negedge clock);
    bus.start    = 1'b1;
    bus.dividend = 32'd100;
    bus.divisor  = 32'd7;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (19) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("abort_quotient", bus.quotient, 0);
    check("abort_remainder", bus.remainder, 0);
    check("abort_end_div", bus.end_div, 0);
    check("abort_state", dut.state, IDLE);
    pulses = 0;
    repeat (80) begin
      @(posedge clock); #1;
      if (bus.end_div === 1'b1) pulses++;
    end
    check("abort_no_pulse", pulses, 0);

    @(negedge clock);
    run_div(32'd9, 32'd2, lat);
    check("fresh_latency", lat, 65);
    check("fresh_quotient", bus.quotient, 4);
    check("fresh_remainder", bus.remainder, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
